circuit_array_bist: RTL and testbench

- Parametrised, registered successor of the three-input gate cell x = NAND(NOT a, b OR c), which equals a OR NOT(b OR c).
- Applies the function across WIDTH independent lanes.
- Normal mode: input and output sit behind a valid/ready handshake with one register stage.
- Built-in self-test mode: sweeps all 8 input combinations across every lane, checks them against a golden table, and reports pass/fail. This replaces manual truth-table benches at integration.

---
 rtl/circuit_pkg.sv | 21 ++
 rtl/gate_cell.sv | 17 +
 rtl/circuit_array_bist.sv | 162 ++++++++++++++++
 tb/tb_circuit_array_bist.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/circuit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : circuit_pkg
//  Brief    : Shared constants and state encoding for circuit_array_bist.
//  Revision : 1.0 - initial release
// ============================================================================
package circuit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SWEEP = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int         SWEEP_LEN      = 8;
    localparam logic [2:0] IDX_LAST       = 3'(SWEEP_LEN - 1);
    localparam logic [7:0] GOLDEN_DEFAULT = 8'b1111_0001;

endpackage
`default_nettype wire

// File: rtl/gate_cell.sv
`default_nettype none
// ============================================================================
//  Module   : gate_cell
//  Brief    : Single-lane combinational gate x = a | ~(b | c).
//  Revision : 1.0 - initial release
// ============================================================================
module gate_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_x
);

    assign o_x = i_a | ~(i_b | i_c);

endmodule
`default_nettype wire

// File: rtl/circuit_array_bist.sv
`default_nettype none
// ============================================================================
//  Module   : circuit_array_bist
//  Brief    : WIDTH-lane registered gate array with handshake and self-test.
//  Revision : 1.0 - initial release
// ============================================================================
module circuit_array_bist
    import circuit_pkg::*;
#(
    parameter int         WIDTH  = 4,
    parameter logic [7:0] GOLDEN = GOLDEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    input  logic             bist_start,
    input  logic             bist_err_inj,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass,
    output logic             bist_fail
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       r_sweep_code;
    logic             r_sweep_vld;
    logic [WIDTH-1:0] r_sweep_res;
    logic [WIDTH-1:0] r_x;
    logic             r_out_valid;
    logic             r_err;
    logic             r_pass;
    logic             r_fail;
    logic             r_done;

    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_sweep_raw;
    logic [WIDTH-1:0] w_sweep_nxt;
    logic [WIDTH-1:0] w_sweep_exp;
    logic [WIDTH-1:0] w_inj;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_start;

    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_xfer     = in_valid && w_in_ready;
    assign w_start    = (r_state == ST_IDLE) && bist_start && !r_out_valid;

    // Sweep path sees the current code replicated onto every lane.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        gate_cell u_data (
            .i_a (a[gi]),
            .i_b (b[gi]),
            .i_c (c[gi]),
            .o_x (w_x_nxt[gi])
        );
        gate_cell u_sweep (
            .i_a (r_idx[2]),
            .i_b (r_idx[1]),
            .i_c (r_idx[0]),
            .o_x (w_sweep_raw[gi])
        );
    end

    always_comb begin
        w_inj    = '0;
        w_inj[0] = bist_err_inj;
    end

    assign w_sweep_nxt = w_sweep_raw ^ w_inj;
    assign w_sweep_exp = {WIDTH{GOLDEN[r_sweep_code]}};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (r_idx == IDX_LAST) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_out_valid  <= 1'b0;
            r_idx        <= '0;
            r_sweep_code <= '0;
            r_sweep_vld  <= 1'b0;
            r_sweep_res  <= '0;
            r_err        <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_xfer) begin
                r_x         <= w_x_nxt;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_start) begin
                r_idx  <= '0;
                r_err  <= 1'b0;
                r_pass <= 1'b0;
                r_fail <= 1'b0;
            end

            if (r_state == ST_SWEEP) begin
                r_sweep_res  <= w_sweep_nxt;
                r_sweep_code <= r_idx;
                r_sweep_vld  <= 1'b1;
                if (r_idx != IDX_LAST) begin
                    r_idx <= r_idx + 3'd1;
                end
            end else begin
                r_sweep_vld <= 1'b0;
            end

            // Each sweep result is judged one edge after it was captured.
            if (r_sweep_vld && (r_sweep_res != w_sweep_exp)) begin
                r_err <= 1'b1;
            end

            if (r_state == ST_DONE) begin
                r_done <= 1'b1;
                r_pass <= !r_err;
                r_fail <= r_err;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign x         = r_x;
    assign bist_busy = (r_state != ST_IDLE);
    assign bist_done = r_done;
    assign bist_pass = r_pass;
    assign bist_fail = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_circuit_array_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_circuit_array_bist
//  Brief    : Self-checking bench for circuit_array_bist (WIDTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_circuit_array_bist;

    localparam int         WIDTH   = 4;
    localparam logic [7:0] GOLD_TB = 8'b1111_0001;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic             bist_start;
    logic             bist_err_inj;
    logic             bist_busy;
    logic             bist_done;
    logic             bist_pass;
    logic             bist_fail;

    int               n_checks = 0;
    int               n_fail   = 0;
    vec_t             tbl[8];
    logic [WIDTH-1:0] sb_q[$];

    circuit_array_bist #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .c            (c),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .x            (x),
        .bist_start   (bist_start),
        .bist_err_inj (bist_err_inj),
        .bist_busy    (bist_busy),
        .bist_done    (bist_done),
        .bist_pass    (bist_pass),
        .bist_fail    (bist_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output side of the scoreboard: one pop per accepted output beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 32'(x), 32'hDEAD);
            end else begin
                check("sb_x", 32'(x), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic send(input int k);
        int waited;
        waited   = 0;
        a        = tbl[k].a;
        b        = tbl[k].b;
        c        = tbl[k].c;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #2;
            waited++;
        end
        check("send_in_ready", 32'(in_ready), 32'd1);
        sb_q.push_back(tbl[k].exp);
        @(posedge clk); #1;
    endtask

    task automatic run_bist(input logic inj, input logic exp_pass);
        bist_start   = 1'b1;
        bist_err_inj = inj;
        @(posedge clk); #1;
        bist_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bist_busy_during", 32'(bist_busy), 32'd1);
            check("bist_done_early", 32'(bist_done), 32'd0);
            if (i == 0) check("bist_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("bist_done_pulse", 32'(bist_done), 32'd1);
        check("bist_busy_after", 32'(bist_busy), 32'd0);
        check("bist_pass", 32'(bist_pass), 32'(exp_pass));
        check("bist_fail", 32'(bist_fail), 32'(!exp_pass));
        bist_err_inj = 1'b0;
        @(posedge clk); #1;
        check("bist_done_cleared", 32'(bist_done), 32'd0);
        check("bist_pass_sticky", 32'(bist_pass), 32'(exp_pass));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] code;
        logic       seen_done;

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                code           = 3'((k + i) % 8);
                tbl[k].a[i]    = code[2];
                tbl[k].b[i]    = code[1];
                tbl[k].c[i]    = code[0];
                tbl[k].exp[i]  = GOLD_TB[code];
            end
        end

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
        out_ready = 1'b0; bist_start = 1'b0; bist_err_inj = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", 32'(x), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(bist_busy), 32'd0);
        check("rst_done", 32'(bist_done), 32'd0);
        check("rst_pass", 32'(bist_pass), 32'd0);
        check("rst_fail", 32'(bist_fail), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-rate stream of all eight codes, rotated per lane.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) send(k);
        in_valid = 1'b0;
        check("stream_last_valid", 32'(out_valid), 32'd1);
        check("stream_last_x", 32'(x), 32'(tbl[7].exp));
        @(posedge clk); #1;
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure then simultaneous drain and accept.
        out_ready = 1'b0;
        send(3);
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_x_stable", 32'(x), 32'(tbl[3].exp));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(5);
        in_valid = 1'b0;
        check("nobubble_valid", 32'(out_valid), 32'd1);
        check("nobubble_x", 32'(x), 32'(tbl[5].exp));
        @(posedge clk); #1;
        check("bp_drained", 32'(out_valid), 32'd0);

        run_bist(1'b0, 1'b1);
        check("bist_x_held", 32'(x), 32'(tbl[5].exp));
        check("bist_out_valid_held", 32'(out_valid), 32'd0);

        // Start with a pending output must be ignored.
        out_ready = 1'b0;
        send(0);
        in_valid   = 1'b0;
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        check("ignored_start_busy", 32'(bist_busy), 32'd0);
        check("ignored_start_pass", 32'(bist_pass), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        run_bist(1'b1, 1'b0);
        check("fail_x_held", 32'(x), 32'(tbl[0].exp));

        // Reset during the fourth sweep cycle.
        bist_start = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midsweep_busy", 32'(bist_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 32'(bist_busy), 32'd0);
        check("midrst_pass", 32'(bist_pass), 32'd0);
        check("midrst_fail", 32'(bist_fail), 32'd0);
        check("midrst_x", 32'(x), 32'd0);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bist_done || bist_busy) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        run_bist(1'b0, 1'b1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
